// File: rtl/lwe_pkg.sv
// Shared constants and types for the LWE (Regev) encrypt/decrypt datapath.
// Holds the default widths and moduli, the encrypt FSM state type and the
// message scale shift (q/p = 2^(CW-PW)).
package lwe_pkg;

  localparam int unsigned LWE_PLAINTEXT_WIDTH    = 6;
  localparam int unsigned LWE_PLAINTEXT_MODULUS  = 64;
  localparam int unsigned LWE_CIPHERTEXT_WIDTH   = 10;
  localparam int unsigned LWE_CIPHERTEXT_MODULUS = 1024;
  localparam int unsigned LWE_DIMENSION          = 1;
  localparam int unsigned LWE_BIG_N              = 30;
  localparam int unsigned LWE_NOISE_WIDTH        = 4;
  localparam int unsigned LWE_SCALE_SHIFT        = LWE_CIPHERTEXT_WIDTH - LWE_PLAINTEXT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUT
  } lwe_state_e;

endpackage

// File: rtl/lwe_encrypt_if.sv
// Handshake bundle for lwe_encrypt: plaintext in, public-key samples in,
// ciphertext out. Vectors pack element i at [i*CW +: CW]; element 0 is b.
//   master : source of pt/pk, sink of ct (testbench / upstream)
//   slave  : the encrypt block
interface lwe_encrypt_if
  import lwe_pkg::*;
#(
  parameter int unsigned PLAINTEXT_WIDTH  = LWE_PLAINTEXT_WIDTH,
  parameter int unsigned CIPHERTEXT_WIDTH = LWE_CIPHERTEXT_WIDTH,
  parameter int unsigned DIMENSION        = LWE_DIMENSION
);
  localparam int unsigned VW = (DIMENSION + 1) * CIPHERTEXT_WIDTH;

  logic                       pt_valid;
  logic                       pt_ready;
  logic [PLAINTEXT_WIDTH-1:0] pt_data;
  logic                       pk_valid;
  logic                       pk_ready;
  logic [VW-1:0]              pk_data;
  logic                       rand_bit;
  logic                       ct_valid;
  logic                       ct_ready;
  logic [VW-1:0]              ct_data;

  modport master (
    output pt_valid, pt_data, pk_valid, pk_data, rand_bit, ct_ready,
    input  pt_ready, pk_ready, ct_valid, ct_data
  );

  modport slave (
    input  pt_valid, pt_data, pk_valid, pk_data, rand_bit, ct_ready,
    output pt_ready, pk_ready, ct_valid, ct_data
  );

endinterface

// File: rtl/lwe_vec_accum.sv
// Multi-lane modular accumulator (modulus 2^W, truncating adds).
// Ports:
//   clk, rst_n : clock, async active-low reset (accumulators -> 0)
//   i_clear    : zero all lanes (wins over i_en)
//   i_en       : load acc + i_add into every lane
//   i_add      : per-lane addend, lane l at [l*W +: W]
//   o_next     : combinational acc + i_add, lets the caller finalise in
//                the same edge as the last add
module lwe_vec_accum #(
  parameter int unsigned LANES = 2,
  parameter int unsigned W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic [LANES*W-1:0] i_add,
  output logic [LANES*W-1:0] o_next
);

  logic [LANES*W-1:0] r_acc;
  logic [LANES*W-1:0] w_next;

  always_comb begin
    w_next = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_next[l*W +: W] = r_acc[l*W +: W] + i_add[l*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_next = w_next;

endmodule

// File: rtl/lwe_encrypt.sv
// Sequential LWE (Regev) encryption. Takes one plaintext m, streams BIG_N
// public-key samples, sums the rand_bit-selected ones mod q, adds m*q/p
// to element 0 and presents DIMENSION+1 ciphertext elements on ct.
// Ports:
//   clk, rst_n : clock, async active-low reset (aborts any encryption)
//   bus        : lwe_encrypt_if.slave (pt / pk / ct handshakes)
//   noise_data : signed error term, sampled with the plaintext
//                (only with LWE_ENCRYPT_NOISE_EN defined)
// Optional feature macro: LWE_ENCRYPT_NOISE_EN
module lwe_encrypt
  import lwe_pkg::*;
#(
  parameter int unsigned PLAINTEXT_MODULUS  = LWE_PLAINTEXT_MODULUS,
  parameter int unsigned PLAINTEXT_WIDTH    = LWE_PLAINTEXT_WIDTH,
  parameter int unsigned DIMENSION          = LWE_DIMENSION,
  parameter int unsigned CIPHERTEXT_MODULUS = LWE_CIPHERTEXT_MODULUS,
  parameter int unsigned CIPHERTEXT_WIDTH   = LWE_CIPHERTEXT_WIDTH,
  parameter int unsigned BIG_N              = LWE_BIG_N
`ifdef LWE_ENCRYPT_NOISE_EN
  ,
  parameter int unsigned NOISE_WIDTH        = LWE_NOISE_WIDTH
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  lwe_encrypt_if.slave                  bus
`ifdef LWE_ENCRYPT_NOISE_EN
  ,
  input  logic signed [NOISE_WIDTH-1:0] noise_data
`endif
);

  localparam int unsigned CW    = CIPHERTEXT_WIDTH;
  localparam int unsigned PW    = PLAINTEXT_WIDTH;
  localparam int unsigned LANES = DIMENSION + 1;
  localparam int unsigned VW    = LANES * CW;
  localparam int unsigned CNT_W = $clog2(BIG_N + 1);
  localparam int unsigned SHIFT = CW - PW;

  // Moduli are powers of two, so reduction is a mask (a no-op on full-width values).
  localparam logic [CW-1:0] W_Q_MASK = CW'(CIPHERTEXT_MODULUS - 1);
  localparam logic [PW-1:0] W_P_MASK = PW'(PLAINTEXT_MODULUS - 1);

  lwe_state_e       r_state;
  logic [PW-1:0]    r_msg;
  logic [CNT_W-1:0] r_count;
  logic [VW-1:0]    r_ct;
  logic             r_pt_ready;
  logic             r_pk_ready;
  logic             r_ct_valid;

  logic             w_pt_fire;
  logic             w_pk_fire;
  logic             w_ct_fire;
  logic             w_last;
  logic [VW-1:0]    w_add;
  logic [VW-1:0]    w_next;
  logic [CW-1:0]    w_offset;
  logic [VW-1:0]    w_final;

  assign w_pt_fire = bus.pt_valid & r_pt_ready;
  assign w_pk_fire = bus.pk_valid & r_pk_ready;
  assign w_ct_fire = r_ct_valid & bus.ct_ready;
  assign w_last    = (r_count == CNT_W'(BIG_N - 1));
  assign w_add     = bus.rand_bit ? bus.pk_data : '0;

  lwe_vec_accum #(
    .LANES (LANES),
    .W     (CW)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_pt_fire),
    .i_en    (w_pk_fire),
    .i_add   (w_add),
    .o_next  (w_next)
  );

`ifdef LWE_ENCRYPT_NOISE_EN
  logic signed [NOISE_WIDTH-1:0] r_noise;
  logic [CW-1:0]                 w_noise_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_noise <= '0;
    end else if (w_pt_fire) begin
      r_noise <= noise_data;
    end
  end

  // Signed size cast sign-extends the noise to CW bits.
  assign w_noise_ext = CW'(r_noise);
  assign w_offset    = (CW'(r_msg) << SHIFT) + w_noise_ext;
`else
  assign w_offset    = CW'(r_msg) << SHIFT;
`endif

  always_comb begin
    w_final          = w_next;
    w_final[CW-1:0]  = (w_next[CW-1:0] + w_offset) & W_Q_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_msg      <= '0;
      r_count    <= '0;
      r_ct       <= '0;
      r_pt_ready <= 1'b1;
      r_pk_ready <= 1'b0;
      r_ct_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pt_fire) begin
            r_msg      <= bus.pt_data & W_P_MASK;
            r_count    <= '0;
            r_pt_ready <= 1'b0;
            r_pk_ready <= 1'b1;
            r_state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_pk_fire) begin
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_ct       <= w_final;
              r_pk_ready <= 1'b0;
              r_ct_valid <= 1'b1;
              r_state    <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (w_ct_fire) begin
            r_ct_valid <= 1'b0;
            r_pt_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_pt_ready <= 1'b1;
          r_pk_ready <= 1'b0;
          r_ct_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pt_ready = r_pt_ready;
  assign bus.pk_ready = r_pk_ready;
  assign bus.ct_valid = r_ct_valid;
  assign bus.ct_data  = r_ct;

endmodule

// File: doc/lwe_encrypt.md
Name: lwe_encrypt

Overview:
- Sequential LWE (Regev) encryption stage that sits directly upstream of decrypt and produces the ciphertext vector that decrypt consumes.
- Accepts one plaintext word, then streams BIG_N public-key samples. Each sample is selected or skipped by a random bit, and selected samples are accumulated mod CIPHERTEXT_MODULUS.
- Adds the scaled message to element 0, then presents the DIMENSION+1 ciphertext elements on a valid/ready output.

Parameters:
- PLAINTEXT_MODULUS, 64, plaintext modulus p; equals 2^PLAINTEXT_WIDTH.
- PLAINTEXT_WIDTH, 6, plaintext bits.
- DIMENSION, 1, LWE dimension n; vectors carry DIMENSION+1 elements.
- CIPHERTEXT_MODULUS, 1024, ciphertext modulus q; equals 2^CIPHERTEXT_WIDTH.
- CIPHERTEXT_WIDTH, 10, ciphertext element bits.
- BIG_N, 30, public-key samples summed per encryption; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pt_valid  in  1  plaintext offered.
- pt_ready  out  1  block can accept a plaintext.
- pt_data  in  PLAINTEXT_WIDTH  message m.
- pk_valid  in  1  public-key sample offered.
- pk_ready  out  1  block can accept a sample.
- pk_data  in  (DIMENSION+1)*CIPHERTEXT_WIDTH  sample; element i is at bits [i*CW +: CW]; element 0 is the b component.
- rand_bit  in  1  selection bit, qualified by the pk handshake.
- ct_valid  out  1  ciphertext available.
- ct_ready  in  1  downstream accepts.
- ct_data  out  (DIMENSION+1)*CIPHERTEXT_WIDTH  ciphertext, same packing as pk_data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FSM goes to IDLE; accumulators, sample counter, ct_data and the message register are 0; pt_ready=1, pk_ready=0, ct_valid=0.
- Reset asserted mid-operation aborts immediately. Partial sums are discarded and no ciphertext is emitted.
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - pt_ready=1, pk_ready=0.
  - On pt_valid&pt_ready: latch m, clear all accumulators, set count=0, go to ACCUM.
- ACCUM:
  - pt_ready=0, pk_ready=1.
  - On each pk_valid&pk_ready: if rand_bit=1, acc[i] <= (acc[i]+pk[i]) mod q for every i; count increments.
  - Cycles with pk_valid=0 change nothing.
  - On the handshake where count==BIG_N-1, the ciphertext is finalised in the same edge: ct[0] = (acc[0] + sel*pk[0] + (m << (CW-PW))) mod q; ct[i>0] = acc[i] + sel*pk[i] mod q. The FSM then goes to OUT.
- OUT:
  - ct_valid=1; pk_ready=0, pt_ready=0.
  - ct_data is registered and held stable until ct_valid&ct_ready, then the FSM returns to IDLE. pt_ready rises the following cycle.
- Arithmetic and widths:
  - All modular adds are unsigned CW-bit truncating adds, since q is a power of 2.
  - Message scale is q/p = 2^(CW-PW).
  - count width is $clog2(BIG_N+1).
- Throughput and latency:
  - Throughput is at most one sample per cycle.
  - Latency from the last pk handshake to ct_valid is 1 cycle.
  - No bubble is inserted between pt accept and the first pk_ready.
- Ignored inputs:
  - pt_valid is ignored outside IDLE.
  - pk_valid is ignored outside ACCUM; rand_bit is ignored without a pk handshake.
- BIG_N=1: the first handshake finalises directly.

Optional Feature:
- Macro: LWE_ENCRYPT_NOISE_EN.
- When defined:
  - Adds input noise_data, signed, NOISE_WIDTH bits (parameter, default 4), sampled on the pt handshake.
  - Finalisation adds the sign-extended noise into ct[0] mod q.
- When undefined: the port and parameter are absent and no noise is added.

Decomposition:
- Shared package lwe_pkg holds:
  - the default width and modulus constants;
  - the state enum typedef for IDLE/ACCUM/OUT;
  - the scale-shift constant CW-PW.
- One sub-module is natural: lwe_vec_accum, a (DIMENSION+1)-lane modular accumulator with clear, enable and add-input. It is also reusable by decrypt's dot product.

Test Plan (defaults CW=10, PW=6, BIG_N=30, scale 16):
1. m=5, all rand_bit=0, pk arbitrary → after 30 pk handshakes, ct={ct0=80, ct1=0}, ct_valid 1 cycle after the last handshake.
2. m=5, all rand_bit=1, every pk element=1 → ct0=110, ct1=30.
3. Wrap-around: m=5, rand_bit=1, pk elements=1000 → 30000 mod 1024=304, so ct0=384, ct1=304.
4. Backpressure and gaps:
   - ct_ready held low 5 cycles → ct_data stable, pt_ready=0, pk_ready=0.
   - pk_valid toggled every other cycle → result identical to scenario 2.
5. Reset mid-ACCUM: assert rst_n low after 10 samples → outputs return to reset values at once. A subsequent scenario 1 yields exactly ct0=80.
6. LWE_ENCRYPT_NOISE_EN with noise=-3 on scenario 1 → ct0=77. With the macro undefined, the same stimulus minus the noise port gives 80.
